// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: turns a raster pixel stream into 2x2 windows
// for the downstream filter datapath, with valid/ready on both sides.
module conv_window_sequencer #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 360,
    parameter int PIX_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               pix_valid_i,
    input  logic [PIX_W-1:0]   pix_i,
    output logic               pix_ready_o,
    output logic               win_valid_o,
    input  logic               win_ready_i,
    output logic [4*PIX_W-1:0] win_o,
    output logic               win_last_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FRAME = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [CW-1:0]      col_q;
    logic [RW-1:0]      row_q;
    logic [PIX_W-1:0]   line_buf [IMG_W];
    logic [PIX_W-1:0]   up_pix;
    logic [PIX_W-1:0]   prev_cur_q;
    logic [PIX_W-1:0]   prev_up_q;
    logic               win_valid_q;
    logic               win_last_q;
    logic [4*PIX_W-1:0] win_q;
    logic               pix_acc;
    logic               win_acc;
    logic               col_end;
    logic               at_last;
    logic               make_win;
    logic               frame_start;

    // Handshake decode; ready depends on win_ready_i, never on pix_valid_i
    assign pix_ready_o = (state_q == S_FRAME) & (~win_valid_q | win_ready_i);
    assign pix_acc     = pix_valid_i & pix_ready_o;
    assign win_acc     = win_valid_q & win_ready_i;
    assign col_end     = (col_q == COL_LAST);
    assign at_last     = col_end & (row_q == ROW_LAST);
    assign frame_start = (state_q == S_IDLE) & start_i;

    // Column 0 and row 0 pixels only prime the buffers
    assign make_win = pix_acc & (row_q != '0) & (col_q != '0);

    // Pixel one row up at the current column
    assign up_pix = line_buf[col_q];

    assign win_valid_o = win_valid_q;
    assign win_last_o  = win_last_q;
    assign win_o       = win_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

    // Next-state logic for the frame sequencing FSM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FRAME;
                end
            end
            S_FRAME: begin
                if (pix_acc && at_last) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!win_valid_q || (win_acc && win_last_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else if (frame_start) begin
            col_q <= '0;
            row_q <= '0;
        end else if (pix_acc) begin
            if (at_last) begin
                col_q <= '0;
                row_q <= '0;
            end else if (col_end) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Line buffer holds the previous row; row 0 fills it before any read
    always_ff @(posedge clk_i) begin
        if (pix_acc) begin
            line_buf[col_q] <= pix_i;
        end
    end

    // Left-hand column of the window, taken from the previous accept
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_cur_q <= '0;
            prev_up_q  <= '0;
        end else if (pix_acc) begin
            prev_cur_q <= pix_i;
            prev_up_q  <= up_pix;
        end
    end

    // Output window register; holds while downstream stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_q       <= '0;
        end else if (make_win) begin
            win_valid_q <= 1'b1;
            win_last_q  <= at_last;
            win_q       <= {prev_up_q, up_pix, prev_cur_q, pix_i};
        end else if (win_acc) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: scoreboard bench for the 2x2 window
// sequencer on a 4x3 frame with pixel(r,c) = 16*r + c.
module tb_conv_window_sequencer;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int PW   = 8;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 1) * (H - 1);

    typedef struct {
        logic [4*PW-1:0] win;
        logic            last;
    } exp_t;

    typedef struct {
        int vpct;
        int rpct;
        bit mid_start;
        int exp_win;
    } vec_t;

    logic            clk_i;
    logic            rst_ni;
    logic            start_i;
    logic            pix_valid_i;
    logic [PW-1:0]   pix_i;
    logic            pix_ready_o;
    logic            win_valid_o;
    logic            win_ready_i;
    logic [4*PW-1:0] win_o;
    logic            win_last_o;
    logic            busy_o;
    logic            done_o;

    conv_window_sequencer #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (PW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .pix_valid_i (pix_valid_i),
        .pix_i       (pix_i),
        .pix_ready_o (pix_ready_o),
        .win_valid_o (win_valid_o),
        .win_ready_i (win_ready_i),
        .win_o       (win_o),
        .win_last_o  (win_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;
    int   idx;
    int   win_cnt;
    int   done_cnt;
    bit   start_req;
    bit   lat_pend;
    vec_t vecs[5];

    function automatic logic [PW-1:0] pix_at(input int r, input int c);
        return PW'(16 * r + c);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample 2 units later, before posedge
    task automatic step(input bit pv, input bit wr);
        exp_t e;
        int   r;
        int   c;
        @(negedge clk_i);
        r           = idx / W;
        c           = idx % W;
        pix_valid_i = pv && (idx < NPIX);
        pix_i       = pix_at(r, c);
        win_ready_i = wr;
        start_i     = start_req;
        start_req   = 1'b0;
        #2;
        if (lat_pend) begin
            check("win_latency", 32'(win_valid_o), 32'd1);
            lat_pend = 1'b0;
        end
        if (win_valid_o && win_ready_i) begin
            if (sb.size() == 0) begin
                check("extra_window", win_o, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                check("win_data", win_o, e.win);
                check("win_last", 32'(win_last_o), 32'(e.last));
                win_cnt++;
            end
        end
        if (pix_valid_i && pix_ready_o) begin
            if (r >= 1 && c >= 1) begin
                e.win  = {pix_at(r-1, c-1), pix_at(r-1, c),
                          pix_at(r, c-1), pix_at(r, c)};
                e.last = (r == H-1) && (c == W-1);
                sb.push_back(e);
                lat_pend = 1'b1;
            end
            idx++;
        end
        if (done_o) done_cnt++;
    endtask

    task automatic begin_frame();
        idx       = 0;
        win_cnt   = 0;
        done_cnt  = 0;
        lat_pend  = 1'b0;
        sb.delete();
        start_req = 1'b1;
    endtask

    task automatic finish_frame(input int vpct, input int rpct,
                                input bit mid_start, input int exp_win);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            if (mid_start && n == 4) start_req = 1'b1;
            step(int'($urandom_range(99)) < vpct,
                 int'($urandom_range(99)) < rpct);
            n++;
        end
        check("done_seen", 32'(done_cnt), 32'd1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("done_once", 32'(done_cnt), 32'd1);
        check("busy_idle", 32'(busy_o), 32'd0);
        check("win_count", 32'(win_cnt), 32'(exp_win));
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("pix_count", 32'(idx), 32'(NPIX));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pix_ready"}, 32'(pix_ready_o), 32'd0);
        check({tag, "_win_valid"}, 32'(win_valid_o), 32'd0);
        check({tag, "_win_last"}, 32'(win_last_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_win"}, win_o, 32'd0);
    endtask

    initial begin
        int n;
        n_cmp       = 0;
        n_bad       = 0;
        idx         = 0;
        win_cnt     = 0;
        done_cnt    = 0;
        start_req   = 1'b0;
        lat_pend    = 1'b0;
        start_i     = 1'b0;
        pix_valid_i = 1'b0;
        pix_i       = '0;
        win_ready_i = 1'b1;
        rst_ni      = 1'b0;

        vecs[0] = '{vpct: 100, rpct: 100, mid_start: 1'b0, exp_win: NWIN};
        vecs[1] = '{vpct: 60,  rpct: 50,  mid_start: 1'b0, exp_win: NWIN};
        vecs[2] = '{vpct: 40,  rpct: 70,  mid_start: 1'b0, exp_win: NWIN};
        vecs[3] = '{vpct: 100, rpct: 100, mid_start: 1'b1, exp_win: NWIN};
        vecs[4] = '{vpct: 100, rpct: 100, mid_start: 1'b0, exp_win: NWIN};

        #12;
        check_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Full frames, gapped traffic, mid-frame start, back-to-back
        for (int i = 0; i < 5; i++) begin
            begin_frame();
            finish_frame(vecs[i].vpct, vecs[i].rpct,
                         vecs[i].mid_start, vecs[i].exp_win);
        end

        // First window stalled for several cycles
        begin_frame();
        n = 0;
        while (!win_valid_o && n < 40) begin
            step(1'b1, 1'b0);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0);
            check("stall_hold", win_o, 32'h0001_1011);
            check("stall_ready", 32'(pix_ready_o), 32'd0);
        end
        finish_frame(100, 100, 1'b0, NWIN);

        // Asynchronous abort after 7 accepted pixels
        begin_frame();
        n = 0;
        while (idx < 7 && n < 40) begin
            step(1'b1, 1'b1);
            n++;
        end
        rst_ni = 1'b0;
        #1;
        check_zero("abort");
        sb.delete();
        lat_pend = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        begin_frame();
        finish_frame(100, 100, 1'b0, NWIN);

        // Final window stalled in FLUSH
        begin_frame();
        n = 0;
        while (idx < NPIX && n < 60) begin
            step(1'b1, 1'b1);
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0);
            check("flush_done", 32'(done_o), 32'd0);
            check("flush_busy", 32'(busy_o), 32'd1);
            check("flush_last", 32'(win_last_o & win_valid_o), 32'd1);
        end
        step(1'b0, 1'b1);
        check("flush_done_acc", 32'(done_o), 32'd0);
        step(1'b0, 1'b0);
        check("done_after_acc", 32'(done_o), 32'd1);
        step(1'b0, 1'b0);
        check("done_pulse_end", 32'(done_o), 32'd0);
        check("flush_idle", 32'(busy_o), 32'd0);
        check("flush_wins", 32'(win_cnt), 32'(NWIN));
        check("flush_done_cnt", 32'(done_cnt), 32'd1);
        check("flush_sb", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
